fir_sample_packer: RTL and testbench

Upstream stage of the dual-channel FIR. Accepts one time-aligned sample pair (CH0, CH1) per handshake and packs 8 consecutive pairs into the 256-bit parallel word the FIR consumes: CH0 lane j at bits [16j+15:16j], CH1 lane j at bits [128+16j+15:128+16j]. It provides AXI-Stream-style backpressure on both sides, zero-pads and flushes partial blocks on `s_tlast`, and counts emitted blocks.

---
 rtl/fir_sample_packer.sv | 110 +++++++++++
 tb/tb_fir_sample_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_packer.sv
// Packs P_SAMPLES CH0/CH1 pairs into one word; a close handshake in cycle N gives the word in cycle N+1.
// Backpressure: s_tready = !m_tvalid || m_tready, so a stalled word also stalls the input.
module fir_sample_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int P_SAMPLES  = 8,
    parameter int CHANNELS   = 2
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     s_tvalid,
    output logic                                     s_tready,
    input  logic [2*DATA_WIDTH-1:0]                  s_tdata,
    input  logic                                     s_tlast,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] m_tdata,
    output logic                                     m_tlast,
    output logic [$clog2(P_SAMPLES)-1:0]             m_pad,
    output logic [15:0]                              blk_count
);
    localparam int IW = $clog2(P_SAMPLES);
    localparam int LW = P_SAMPLES * DATA_WIDTH;
    localparam logic [IW-1:0] LAST_LANE = IW'(P_SAMPLES - 1);

    logic [IW-1:0]                            idx_q, idx_d;
    logic [LW-1:0]                            pk0_q, pk0_d, pk1_q, pk1_d;
    logic [LW-1:0]                            mrg0, mrg1;
    logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] dat_q, dat_d;
    logic                                     mvld_q, mvld_d;
    logic                                     mlast_q, mlast_d;
    logic [IW-1:0]                            pad_q, pad_d;
    logic [15:0]                              blk_q, blk_d;
    logic                                     in_hs, out_hs, close;

    assign s_tready  = !mvld_q || m_tready;
    assign in_hs     = s_tvalid && s_tready;
    assign out_hs    = mvld_q && m_tready;
    assign close     = in_hs && (idx_q == LAST_LANE || s_tlast);

    assign m_tvalid  = mvld_q;
    assign m_tdata   = dat_q;
    assign m_tlast   = mlast_q;
    assign m_pad     = pad_q;
    assign blk_count = blk_q;

    // Pack register with the incoming pair merged at idx; lanes above idx are forced to zero.
    always_comb begin
        mrg0 = '0;
        mrg1 = '0;
        for (int j = 0; j < P_SAMPLES; j++) begin
            if (IW'(j) < idx_q) begin
                mrg0[j*DATA_WIDTH +: DATA_WIDTH] = pk0_q[j*DATA_WIDTH +: DATA_WIDTH];
                mrg1[j*DATA_WIDTH +: DATA_WIDTH] = pk1_q[j*DATA_WIDTH +: DATA_WIDTH];
            end else if (IW'(j) == idx_q) begin
                mrg0[j*DATA_WIDTH +: DATA_WIDTH] = s_tdata[DATA_WIDTH-1:0];
                mrg1[j*DATA_WIDTH +: DATA_WIDTH] = s_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    always_comb begin
        idx_d   = idx_q;
        pk0_d   = pk0_q;
        pk1_d   = pk1_q;
        dat_d   = dat_q;
        mvld_d  = mvld_q;
        mlast_d = mlast_q;
        pad_d   = pad_q;
        blk_d   = blk_q;
        if (out_hs) begin
            mvld_d = 1'b0;
            blk_d  = blk_q + 16'd1;
        end
        if (close) begin
            idx_d   = '0;
            pk0_d   = '0;
            pk1_d   = '0;
            dat_d   = {mrg1, mrg0};
            pad_d   = LAST_LANE - idx_q;
            mlast_d = s_tlast;
            mvld_d  = 1'b1;
        end else if (in_hs) begin
            idx_d = idx_q + 1'b1;
            pk0_d = mrg0;
            pk1_d = mrg1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q   <= '0;
            pk0_q   <= '0;
            pk1_q   <= '0;
            dat_q   <= '0;
            mvld_q  <= 1'b0;
            mlast_q <= 1'b0;
            pad_q   <= '0;
            blk_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            pk0_q   <= pk0_d;
            pk1_q   <= pk1_d;
            dat_q   <= dat_d;
            mvld_q  <= mvld_d;
            mlast_q <= mlast_d;
            pad_q   <= pad_d;
            blk_q   <= blk_d;
        end
    end
endmodule

// File: tb/tb_fir_sample_packer.sv
// Directed table-driven bench for fir_sample_packer plus hand sequences for reset, stall and counter wrap.
module tb_fir_sample_packer;
    logic         clk = 1'b0;
    logic         nrst;
    logic         s_tvalid, s_tready, s_tlast;
    logic [31:0]  s_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    logic [255:0] m_tdata;
    logic [2:0]   m_pad;
    logic [15:0]  blk_count;

    int n_tests = 0;
    int n_fail  = 0;

    fir_sample_packer #(.DATA_WIDTH(16), .P_SAMPLES(8), .CHANNELS(2)) dut (
        .clk(clk), .nrst(nrst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_pad(m_pad), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vld;
        logic [15:0]  c0;
        logic [15:0]  c1;
        logic         last;
        logic         rdy;
        logic         e_srdy;
        logic         e_mvld;
        logic [2:0]   e_pad;
        logic         e_mlast;
        logic [15:0]  e_blk;
        logic         dchk;
        logic [255:0] e_dat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [15:0] c0, input logic [15:0] c1,
                                input logic last, input logic rdy, input logic e_srdy,
                                input logic e_mvld, input logic [2:0] e_pad, input logic e_mlast,
                                input logic [15:0] e_blk, input logic dchk, input logic [255:0] e_dat);
        vec_t v;
        v.vld = vld; v.c0 = c0; v.c1 = c1; v.last = last; v.rdy = rdy;
        v.e_srdy = e_srdy; v.e_mvld = e_mvld; v.e_pad = e_pad; v.e_mlast = e_mlast;
        v.e_blk = e_blk; v.dchk = dchk; v.e_dat = e_dat;
        return v;
    endfunction

    function automatic logic [15:0] bp_c0(input int n);
        return 16'h1000 + 16'(n);
    endfunction

    function automatic logic [15:0] bp_c1(input int n);
        return 16'hF000 - 16'(n);
    endfunction

    function automatic logic [255:0] bp_word(input int k);
        logic [255:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            w[16*j +: 16]       = bp_c0(8*k + j);
            w[128 + 16*j +: 16] = bp_c1(8*k + j);
        end
        return w;
    endfunction

    initial begin
        logic [255:0] w_full, w_part, w_one;
        int sent, got, stall;
        bit released;

        w_full = {16'h8008, 16'h8007, 16'h8006, 16'h8005, 16'h8004, 16'h8003, 16'h8002, 16'h8001,
                  16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        w_part = {80'h0, 16'h3333, 16'h2222, 16'h1111, 80'h0, 16'h8000, 16'h0000, 16'h7FFF};
        w_one  = {112'h0, 16'h5555, 112'h0, 16'hAAAA};

        for (int j = 0; j < 8; j++)
            vecs[j] = mk(1, 16'(j + 1), 16'h8001 + 16'(j), 0, 1, 1, (j == 7), 3'd0, 0, 16'd0,
                         (j == 7), w_full);
        vecs[8]  = mk(1, 16'h7FFF, 16'h1111, 0, 1, 1, 0, 3'd0, 0, 16'd1, 0, '0);
        vecs[9]  = mk(1, 16'h0000, 16'h2222, 0, 1, 1, 0, 3'd0, 0, 16'd1, 0, '0);
        vecs[10] = mk(1, 16'h8000, 16'h3333, 1, 1, 1, 1, 3'd5, 1, 16'd1, 1, w_part);
        vecs[11] = mk(1, 16'hAAAA, 16'h5555, 1, 1, 1, 1, 3'd7, 1, 16'd2, 1, w_one);
        vecs[12] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 3'd7, 1, 16'd2, 1, w_one);
        vecs[13] = mk(1, 16'h0BAD, 16'h0BAD, 1, 0, 0, 1, 3'd7, 1, 16'd2, 1, w_one);
        vecs[14] = mk(0, 16'h0000, 16'h0000, 1, 1, 1, 0, 3'd7, 1, 16'd3, 0, '0);
        vecs[15] = mk(0, 16'h0000, 16'h0000, 0, 1, 1, 0, 3'd7, 1, 16'd3, 0, '0);

        nrst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
        #2;
        chk("rst_srdy", s_tready, 1);
        chk("rst_mvld", m_tvalid, 0);
        @(negedge clk) nrst = 1'b1;

        // Three pairs then a mid-block reset: they must never show up.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = {16'hEE00 + 16'(i), 16'hDD00 + 16'(i)};
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        nrst     = 1'b0;
        #1;
        chk("midrst_mvld", m_tvalid, 0);
        chk("midrst_mdat", m_tdata, '0);
        chk("midrst_mlast", m_tlast, 0);
        chk("midrst_mpad", m_pad, 0);
        chk("midrst_blk", blk_count, 0);
        chk("midrst_srdy", s_tready, 1);
        @(negedge clk) nrst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_tvalid = vecs[i].vld;
            s_tdata  = {vecs[i].c1, vecs[i].c0};
            s_tlast  = vecs[i].last;
            m_tready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_srdy", i), s_tready, vecs[i].e_srdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_mvld", i), m_tvalid, vecs[i].e_mvld);
            chk($sformatf("v%0d_blk", i), blk_count, vecs[i].e_blk);
            if (vecs[i].e_mvld) begin
                chk($sformatf("v%0d_pad", i), m_pad, vecs[i].e_pad);
                chk($sformatf("v%0d_mlast", i), m_tlast, vecs[i].e_mlast);
            end
            if (vecs[i].dchk)
                chk($sformatf("v%0d_dat", i), m_tdata, vecs[i].e_dat);
        end

        // Backpressure: stall the first word for 20 cycles, then stream 4 words total.
        s_tlast = 1'b0; sent = 0; got = 0; stall = 0; released = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 4; cyc++) begin
            @(negedge clk);
            if (m_tvalid && got == 0 && stall < 20) begin
                m_tready = 1'b0;
                chk("bp_hold_dat", m_tdata, bp_word(0));
                stall++;
            end else begin
                m_tready = 1'b1;
            end
            s_tvalid = (sent < 32);
            s_tdata  = {bp_c1(sent), bp_c0(sent)};
            #1;
            if (!m_tready) begin
                chk("bp_srdy_low", s_tready, 0);
            end else if (stall == 20 && !released) begin
                chk("bp_srdy_release", s_tready, 1);
                released = 1'b1;
            end
            if (m_tvalid && m_tready) begin
                chk($sformatf("bp_word%0d", got), m_tdata, bp_word(got));
                got++;
            end
            if (s_tvalid && s_tready) sent++;
        end
        chk("bp_words_seen", got, 4);
        chk("bp_stall_cycles", stall, 20);
        @(negedge clk) s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_blk", blk_count, 7);

        // Counter wrap: 65536 single-pair words from a fresh reset.
        @(negedge clk) nrst = 1'b0;
        @(negedge clk) nrst = 1'b1;
        s_tvalid = 1'b1; s_tlast = 1'b1; m_tready = 1'b1; s_tdata = 32'h1234_5678;
        repeat (65536) @(posedge clk);
        @(negedge clk) s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_blk_zero", blk_count, 16'h0000);
        chk("wrap_mvld", m_tvalid, 0);
        @(negedge clk) s_tvalid = 1'b1;
        @(negedge clk) s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_blk_one", blk_count, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
